// File: rtl/mouse_packet_tx.sv
// mouse_packet_tx: CPU-staged 8-byte frame driver for the SPART transmitter
// (BA 11 stat_hi stat_lo x_hi x_lo y_hi y_lo), 3 cycles/byte when tbr stays high.
// Optional macro TX_PENDING_EN adds a one-deep pending send queued while busy.
module mouse_packet_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        tbr,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TBR = 2'd1,
    LOAD     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] stat_r, x_r, y_r;
  logic [15:0] snap_s, snap_x, snap_y;
  logic [7:0]  cur_byte;
  logic        send_req;

`ifdef TX_PENDING_EN
  logic        pend;
`endif

  // Only bit 0 of a command write means "send"; everything else is ignored.
  assign send_req = we && (addr == 2'b11) && data_in[0];

  // CPU staging registers, writable at any time (frames use the snapshot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_r <= 16'h0000;
      x_r    <= 16'h0000;
      y_r    <= 16'h0000;
    end else if (we) begin
      case (addr)
        2'b00:   stat_r <= data_in;
        2'b01:   x_r    <= data_in;
        2'b10:   y_r    <= data_in;
        default: ;
      endcase
    end
  end

  // Register read window, combinational from addr.
  always_comb begin
    data_out = 16'h0000;
    case (addr)
      2'b00:   data_out = stat_r;
      2'b01:   data_out = x_r;
      2'b10:   data_out = y_r;
      default: data_out = {15'b0, busy};
    endcase
  end

  // Frame byte for the current index, built only from the snapshot.
  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      3'd0:    cur_byte = 8'hBA;
      3'd1:    cur_byte = 8'h11;
      3'd2:    cur_byte = snap_s[15:8];
      3'd3:    cur_byte = snap_s[7:0];
      3'd4:    cur_byte = snap_x[15:8];
      3'd5:    cur_byte = snap_x[7:0];
      3'd6:    cur_byte = snap_y[15:8];
      default: cur_byte = snap_y[7:0];
    endcase
  end

  // Transmit FSM; all outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      snap_s  <= 16'h0000;
      snap_x  <= 16'h0000;
      snap_y  <= 16'h0000;
      tx_data <= 8'h00;
      tx_load <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef TX_PENDING_EN
      pend    <= 1'b0;
`endif
    end else begin
      tx_load <= 1'b0;
      done    <= 1'b0;
`ifdef TX_PENDING_EN
      // A request during a frame is remembered once; extra ones fold into it.
      if (state != IDLE && send_req)
        pend <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (send_req) begin
            snap_s <= stat_r;
            snap_x <= x_r;
            snap_y <= y_r;
            idx    <= 3'd0;
            busy   <= 1'b1;
            state  <= WAIT_TBR;
          end
        end
        WAIT_TBR: begin
          if (tbr) begin
            tx_load <= 1'b1;
            tx_data <= cur_byte;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // Gives the SPART one cycle to drop tbr before it is looked at again.
          state <= GAP;
        end
        GAP: begin
          if (idx == 3'd7) begin
            done <= 1'b1;
`ifdef TX_PENDING_EN
            // A request landing on this very edge is treated like a pending one.
            if (pend || send_req) begin
              snap_s <= stat_r;
              snap_x <= x_r;
              snap_y <= y_r;
              pend   <= 1'b0;
              idx    <= 3'd0;
              state  <= WAIT_TBR;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end else begin
            idx   <= idx + 3'd1;
            state <= WAIT_TBR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_packet_tx.sv
// Bench for mouse_packet_tx: random staging values and tbr stalls checked
// against an expected-byte model built from the frame layout.
// Covers reset, timing, stalls, snapshot isolation, busy sends, mid-frame reset.
module tb_mouse_packet_tx;

  logic        clk = 1'b0;
  logic        rst, we, tbr;
  logic [1:0]  addr;
  logic [15:0] data_in, data_out;
  logic [7:0]  tx_data;
  logic        tx_load, busy, done;

  mouse_packet_tx dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .tbr(tbr), .tx_data(tx_data), .tx_load(tx_load),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [15:0] st_s, st_x, st_y;   // model of the staging registers

  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte handed to the SPART, with the cycle it appeared in.
  always @(negedge clk) begin
    if (tx_load) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame layout: header BA 11 then status, X, Y, each high byte first.
  function automatic logic [7:0] frame_byte(input logic [15:0] s, input logic [15:0] x,
                                            input logic [15:0] y, input int k);
    logic [63:0] f;
    f = {8'hBA, 8'h11, s, x, y};
    return f[63-8*k -: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; data_in = d;
    tick;
    we = 1'b0;
    case (a)
      2'b00:   st_s = d;
      2'b01:   st_x = d;
      2'b10:   st_y = d;
      default: ;
    endcase
  endtask

  task automatic send;
    cpu_write(2'b11, 16'h0001);
  endtask

  task automatic write_stage(input logic [15:0] s, input logic [15:0] x, input logic [15:0] y);
    cpu_write(2'b00, s);
    cpu_write(2'b01, x);
    cpu_write(2'b10, y);
  endtask

  // Wait (bounded) for `target` done pulses; report whether busy ever dropped before.
  task automatic wait_done(input string tag, input int target, input int budget, input bit rnd,
                           output bit busy_low, output int done_cyc);
    int n;
    n = 0; busy_low = 1'b0; done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (rnd) tbr = 1'($urandom_range(0, 1));
      tick;
      if (done) begin
        n++;
        done_cyc = cyc;
      end
      if (n == target) break;
      if (!busy) busy_low = 1'b1;
    end
    tbr = 1'b1;
    chk({tag, "_done_count"}, n, target);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] s, input logic [15:0] x,
                             input logic [15:0] y, input int base);
    chk({tag, "_len"}, (got_q.size() >= base + 8), 1);
    for (int k = 0; k < 8; k++) begin
      if (base + k < got_q.size())
        chk($sformatf("%s_b%0d", tag, k), got_q[base+k], frame_byte(s, x, y, k));
    end
  endtask

  task automatic check_reads(input string tag, input logic exp_busy);
    addr = 2'b00; #1; chk({tag, "_rd_stat"}, data_out, st_s);
    addr = 2'b01; #1; chk({tag, "_rd_x"},    data_out, st_x);
    addr = 2'b10; #1; chk({tag, "_rd_y"},    data_out, st_y);
    addr = 2'b11; #1; chk({tag, "_rd_cmd"},  data_out, {15'b0, exp_busy});
  endtask

  initial begin
    bit blow;
    int dcyc, c0, n;
    logic [15:0] s1, x1, y1, s2, y2, rs, rx, ry;

    rst = 1'b1; we = 1'b0; addr = 2'b00; data_in = 16'h0000; tbr = 1'b1;
    st_s = 16'h0; st_x = 16'h0; st_y = 16'h0;
    repeat (3) tick;
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_reads("rst", 1'b0);
    rst = 1'b0;
    tick;

    // Directed frame with tbr held high: byte values and exact cadence.
    write_stage(16'h1234, 16'h00A5, 16'hFF01);
    check_reads("stage", 1'b0);
    got_q.delete(); got_cyc.delete();
    send;
    c0 = cyc;
    chk("t1_busy_after_send", busy, 1);
    chk("t1_load_in_wait", tx_load, 0);
    addr = 2'b11; #1; chk("t1_rd_busy", data_out, 16'h0001);
    wait_done("t1", 1, 200, 1'b0, blow, dcyc);
    chk("t1_busy_steady", blow, 0);
    check_frame("t1", 16'h1234, 16'h00A5, 16'hFF01, 0);
    for (int k = 0; k < 8; k++)
      if (k < got_cyc.size())
        chk($sformatf("t1_cyc%0d", k), got_cyc[k] - c0, 1 + 3 * k);
    chk("t1_done_cyc", dcyc - c0, 24);
    chk("t1_busy_at_done", busy, 0);
    tick;
    chk("t1_done_width", done, 0);

    // tbr stalled for 10 cycles before byte 4.
    got_q.delete();
    send;
    for (int i = 0; i < 200 && got_q.size() < 4; i++) tick;
    tbr = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (tx_load || !busy) n++;
    end
    chk("t2_stall_quiet", n, 0);
    chk("t2_stall_count", got_q.size(), 4);
    tbr = 1'b1;
    wait_done("t2", 1, 200, 1'b0, blow, dcyc);
    chk("t2_busy_steady", blow, 0);
    check_frame("t2", 16'h1234, 16'h00A5, 16'hFF01, 0);

    // Staging rewrite mid-frame must not leak into the frame in flight.
    got_q.delete();
    s1 = st_s; x1 = st_x; y1 = st_y;
    send;
    for (int i = 0; i < 200 && got_q.size() < 2; i++) tick;
    cpu_write(2'b01, 16'hBEEF);
    wait_done("t3a", 1, 200, 1'b0, blow, dcyc);
    check_frame("t3a", s1, x1, y1, 0);
    got_q.delete();
    send;
    wait_done("t3b", 1, 200, 1'b0, blow, dcyc);
    check_frame("t3b", s1, 16'hBEEF, y1, 0);

    // Random staging values with random tbr stalls.
    for (int r = 0; r < 6; r++) begin
      rs = 16'($urandom); rx = 16'($urandom); ry = 16'($urandom);
      write_stage(rs, rx, ry);
      got_q.delete();
      send;
      wait_done($sformatf("rnd%0d", r), 1, 600, 1'b1, blow, dcyc);
      chk($sformatf("rnd%0d_busy_steady", r), blow, 0);
      check_frame($sformatf("rnd%0d", r), rs, rx, ry, 0);
      chk($sformatf("rnd%0d_len_exact", r), got_q.size(), 8);
      tick;
    end

    // Send while busy, with staging updates around it.
    s1 = 16'h5A5A; x1 = 16'h0F0F; y1 = 16'hC3C3;
    write_stage(s1, x1, y1);
    got_q.delete();
    send;
    for (int i = 0; i < 200 && got_q.size() < 3; i++) tick;
    y2 = 16'h7E81; s2 = 16'h9001;
    cpu_write(2'b10, y2);
    send;
    cpu_write(2'b00, s2);
    send;
`ifdef TX_PENDING_EN
    wait_done("t4", 2, 400, 1'b0, blow, dcyc);
    chk("t4_busy_steady", blow, 0);
    repeat (30) tick;
    chk("t4_loads", got_q.size(), 16);
    check_frame("t4a", s1, x1, y1, 0);
    check_frame("t4b", s2, x1, y2, 8);
`else
    wait_done("t4", 1, 400, 1'b0, blow, dcyc);
    chk("t4_busy_steady", blow, 0);
    repeat (30) tick;
    chk("t4_loads", got_q.size(), 8);
    check_frame("t4a", s1, x1, y1, 0);
`endif
    chk("t4_idle", busy, 0);

    // Reset while byte index 4 is being loaded.
    got_q.delete();
    send;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (tx_load) n++;
      if (n == 5) break;
    end
    chk("t5_reached_byte4", n, 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx_load", tx_load, 0);
    chk("t5_rst_busy", busy, 0);
    st_s = 16'h0; st_x = 16'h0; st_y = 16'h0;
    check_reads("t5", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick;
    rs = 16'($urandom); rx = 16'($urandom); ry = 16'($urandom);
    write_stage(rs, rx, ry);
    got_q.delete();
    send;
    wait_done("t5", 1, 200, 1'b0, blow, dcyc);
    check_frame("t5", rs, rx, ry, 0);
    chk("t5_len_exact", got_q.size(), 8);

    // Command writes with bit 0 clear are no-ops.
    got_q.delete();
    cpu_write(2'b11, 16'h0002);
    cpu_write(2'b11, 16'hFFFE);
    repeat (10) tick;
    chk("t6_busy", busy, 0);
    chk("t6_loads", got_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
